// File: rtl/fwd_pkg.sv
// fwd_pkg
// Shared definitions for the operand-forwarding scoreboard.
//   DATA_W_DEF / REG_AW_DEF : default data and register-address widths
//   REG_ZERO                : the hardwired-zero register; it is never
//                             recorded as a destination and never matched
//   entry_t                 : layout of one in-flight write at default widths
package fwd_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_AW_DEF = 4;
    localparam int REG_ZERO   = 0;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_DEF-1:0] addr;
        logic                  ready;
        logic [DATA_W_DEF-1:0] data;
    } entry_t;

endpackage

// File: rtl/fwd_lookup.sv
// fwd_lookup
// Single-port priority match over the in-flight entry vector.
// Returns the youngest (lowest-index) valid entry whose destination equals
// src_addr. Register zero never matches.
// Ports:
//   ent_valid/ent_addr/ent_ready/ent_data : entry vector, slot 0 youngest
//   src_addr                              : register being read
//   hit                                   : a matching entry exists
//   ready                                 : the winning entry holds its data
//   data                                  : data of the winning entry
module fwd_lookup
    import fwd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = 3
) (
    input  logic [DEPTH-1:0]             ent_valid,
    input  logic [DEPTH-1:0][REG_AW-1:0] ent_addr,
    input  logic [DEPTH-1:0]             ent_ready,
    input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
    input  logic [REG_AW-1:0]            src_addr,
    output logic                         hit,
    output logic                         ready,
    output logic [DATA_W-1:0]            data
);

    // Scan from oldest to youngest so the youngest match overwrites any
    // older one; an older ready entry therefore cannot mask a younger
    // unready one.
    always_comb begin
        hit   = 1'b0;
        ready = 1'b0;
        data  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_valid[i] && (ent_addr[i] == src_addr) &&
                (src_addr != REG_AW'(REG_ZERO))) begin
                hit   = 1'b1;
                ready = ent_ready[i];
                data  = ent_data[i];
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
// Operand-forwarding and load-use hazard unit. A DEPTH-entry shift register
// records every in-flight register write; each of NUM_SRC read ports takes
// the youngest matching in-flight value or falls back to register-file data,
// and a stall is raised when the youngest match is a load still waiting.
// Optional feature macro: FWD_STATS_EN adds saturating stall/forward counters.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   hold_i                   : freeze all entries
//   flush_i                  : squash slot 0 and the incoming write
//   wr_valid_i/addr/ready/data : write entering EX
//   ld_valid_i, ld_data_i    : load data for the entry in LD_SLOT
//   src_addr_i, rf_data_i    : packed read addresses and register-file data
//   src_data_o, src_fwd_o    : resolved operands and per-port forward flags
//   stall_o                  : load-use hazard on any port
//   stall_cnt_o, fwd_cnt_o   : statistics (FWD_STATS_EN only)
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2,
    parameter int LD_SLOT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold_i,
    input  logic                      flush_i,
    input  logic                      wr_valid_i,
    input  logic [REG_AW-1:0]         wr_addr_i,
    input  logic                      wr_ready_i,
    input  logic [DATA_W-1:0]         wr_data_i,
    input  logic                      ld_valid_i,
    input  logic [DATA_W-1:0]         ld_data_i,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr_i,
    input  logic [NUM_SRC*DATA_W-1:0] rf_data_i,
    output logic [NUM_SRC*DATA_W-1:0] src_data_o,
    output logic [NUM_SRC-1:0]        src_fwd_o,
`ifdef FWD_STATS_EN
    output logic [15:0]               stall_cnt_o,
    output logic [15:0]               fwd_cnt_o,
`endif
    output logic                      stall_o
);

    // A load parked in the last slot has no successor to land in when the
    // pipeline advances, so its completion is simply dropped with it.
    localparam bit LD_HAS_NEXT = (LD_SLOT + 1 < DEPTH);
    localparam int LD_NEXT     = LD_HAS_NEXT ? LD_SLOT + 1 : LD_SLOT;

    logic [DEPTH-1:0]             valid_q;
    logic [DEPTH-1:0]             ready_q;
    logic [DEPTH-1:0][REG_AW-1:0] addr_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;

    logic ld_hit;
    assign ld_hit = ld_valid_i && valid_q[LD_SLOT] && !ready_q[LD_SLOT];

    // Entry pipeline. The load-completion assignment comes after the shift
    // copy so it wins when both target the same slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            ready_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (!hold_i) begin
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1] & ~(flush_i && (i == 1));
                addr_q[i]  <= addr_q[i-1];
                ready_q[i] <= ready_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
            valid_q[0] <= wr_valid_i & ~flush_i & (wr_addr_i != REG_AW'(REG_ZERO));
            addr_q[0]  <= wr_addr_i;
            ready_q[0] <= wr_ready_i;
            data_q[0]  <= wr_data_i;
            if (LD_HAS_NEXT && ld_hit) begin
                ready_q[LD_NEXT] <= 1'b1;
                data_q[LD_NEXT]  <= ld_data_i;
            end
        end else if (ld_hit) begin
            ready_q[LD_SLOT] <= 1'b1;
            data_q[LD_SLOT]  <= ld_data_i;
        end
    end

    logic [NUM_SRC-1:0]             lk_hit;
    logic [NUM_SRC-1:0]             lk_ready;
    logic [NUM_SRC-1:0][DATA_W-1:0] lk_data;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_port
        fwd_lookup #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH)
        ) u_lookup (
            .ent_valid (valid_q),
            .ent_addr  (addr_q),
            .ent_ready (ready_q),
            .ent_data  (data_q),
            .src_addr  (src_addr_i[k*REG_AW +: REG_AW]),
            .hit       (lk_hit[k]),
            .ready     (lk_ready[k]),
            .data      (lk_data[k])
        );
    end

    // Output resolution. During reset the entries may still hold stale
    // contents, so forwarding and stalls are masked until they are cleared.
    always_comb begin
        src_data_o = rf_data_i;
        src_fwd_o  = '0;
        stall_o    = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!rst && lk_hit[k]) begin
                if (lk_ready[k]) begin
                    src_fwd_o[k]                   = 1'b1;
                    src_data_o[k*DATA_W +: DATA_W] = lk_data[k];
                end else begin
                    stall_o = 1'b1;
                end
            end
        end
    end

`ifdef FWD_STATS_EN
    logic [15:0] fwd_pop;
    logic [16:0] fwd_sum;

    always_comb begin
        fwd_pop = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            fwd_pop = fwd_pop + 16'(src_fwd_o[k]);
        end
        fwd_sum = {1'b0, fwd_cnt_o} + {1'b0, fwd_pop};
    end

    // Counters only advance while the pipeline moves and stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
            fwd_cnt_o   <= '0;
        end else if (!hold_i) begin
            if (stall_o && (stall_cnt_o != 16'hFFFF)) begin
                stall_cnt_o <= stall_cnt_o + 16'd1;
            end
            fwd_cnt_o <= fwd_sum[16] ? 16'hFFFF : fwd_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard
// Directed testbench for fwd_scoreboard with default parameters
// (DATA_W=16, REG_AW=4, DEPTH=3, NUM_SRC=2, LD_SLOT=1).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 time
// unit later, well clear of the next edge.
module tb_fwd_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold_i;
    logic        flush_i;
    logic        wr_valid_i;
    logic [3:0]  wr_addr_i;
    logic        wr_ready_i;
    logic [15:0] wr_data_i;
    logic        ld_valid_i;
    logic [15:0] ld_data_i;
    logic [7:0]  src_addr_i;
    logic [31:0] rf_data_i;
    logic [31:0] src_data_o;
    logic [1:0]  src_fwd_o;
    logic        stall_o;
`ifdef FWD_STATS_EN
    logic [15:0] stall_cnt_o;
    logic [15:0] fwd_cnt_o;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    fwd_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .hold_i     (hold_i),
        .flush_i    (flush_i),
        .wr_valid_i (wr_valid_i),
        .wr_addr_i  (wr_addr_i),
        .wr_ready_i (wr_ready_i),
        .wr_data_i  (wr_data_i),
        .ld_valid_i (ld_valid_i),
        .ld_data_i  (ld_data_i),
        .src_addr_i (src_addr_i),
        .rf_data_i  (rf_data_i),
        .src_data_o (src_data_o),
        .src_fwd_o  (src_fwd_o),
`ifdef FWD_STATS_EN
        .stall_cnt_o(stall_cnt_o),
        .fwd_cnt_o  (fwd_cnt_o),
`endif
        .stall_o    (stall_o)
    );

    always #5 clk = ~clk;

    // Drive the write/load/control inputs for the coming cycle.
    task automatic applyStimulus(input logic wv, input logic [3:0] wa, input logic wr,
                                 input logic [15:0] wd, input logic fl, input logic hd,
                                 input logic lv, input logic [15:0] ld);
        wr_valid_i = wv;
        wr_addr_i  = wa;
        wr_ready_i = wr;
        wr_data_i  = wd;
        flush_i    = fl;
        hold_i     = hd;
        ld_valid_i = lv;
        ld_data_i  = ld;
    endtask

    task automatic setSources(input logic [3:0] a0, input logic [3:0] a1,
                              input logic [15:0] rf0, input logic [15:0] rf1);
        src_addr_i = {a1, a0};
        rf_data_i  = {rf1, rf0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare all combinational outputs against hand-computed values.
    task automatic checkOutput(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                               input logic [1:0] ef, input logic es);
        #1;
        n_compared++;
        assert ({src_data_o, src_fwd_o, stall_o} === {e1, e0, ef, es})
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed data=%h fwd=%b stall=%b, expected data=%h fwd=%b stall=%b",
                   tag, src_data_o, src_fwd_o, stall_o, {e1, e0}, ef, es);
        end
    endtask

`ifdef FWD_STATS_EN
    task automatic checkCounters(input string tag, input logic [15:0] es, input logic [15:0] ef);
        n_compared++;
        assert ({stall_cnt_o, fwd_cnt_o} === {es, ef})
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed stall_cnt=%h fwd_cnt=%h, expected stall_cnt=%h fwd_cnt=%h",
                   tag, stall_cnt_o, fwd_cnt_o, es, ef);
        end
    endtask
`endif

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        setSources(4'd3, 4'd5, 16'h1111, 16'h2222);
        tick();
        checkOutput("reset", 16'h1111, 16'h2222, 2'b00, 0);
        tick();
        rst = 1'b0;
        checkOutput("post_reset", 16'h1111, 16'h2222, 2'b00, 0);
`ifdef FWD_STATS_EN
        checkCounters("counters_reset", 16'h0, 16'h0);
`endif

        // ALU result for r3 travels through slots 0, 1, 2 and then retires.
        applyStimulus(1, 4'd3, 1, 16'hABCD, 0, 0, 0, 16'h0);
        checkOutput("same_cycle_write", 16'h1111, 16'h2222, 2'b00, 0);
        tick();
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        checkOutput("alu_slot0", 16'hABCD, 16'h2222, 2'b01, 0);
        tick();
        checkOutput("alu_slot1", 16'hABCD, 16'h2222, 2'b01, 0);
        tick();
        checkOutput("alu_slot2", 16'hABCD, 16'h2222, 2'b01, 0);
        tick();
        checkOutput("alu_retired", 16'h1111, 16'h2222, 2'b00, 0);

        // Load to r5 read on port 1: stall until data returns in slot 1.
        applyStimulus(1, 4'd5, 0, 16'hDEAD, 0, 0, 0, 16'h0);
        checkOutput("load_enter", 16'h1111, 16'h2222, 2'b00, 0);
        tick();
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        checkOutput("load_use_stall", 16'h1111, 16'h2222, 2'b00, 1);
        tick();
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 1, 16'h0BEE);
        checkOutput("load_wait_slot1", 16'h1111, 16'h2222, 2'b00, 1);
        tick();
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        checkOutput("load_fwd_slot2", 16'h1111, 16'h0BEE, 2'b10, 0);
        tick();
        checkOutput("load_retired", 16'h1111, 16'h2222, 2'b00, 0);

        // r4 written twice, then a younger unready load hides both.
        setSources(4'd4, 4'd5, 16'h1111, 16'h2222);
        applyStimulus(1, 4'd4, 1, 16'h0001, 0, 0, 0, 16'h0);
        tick();
        applyStimulus(1, 4'd4, 1, 16'h0002, 0, 0, 0, 16'h0);
        tick();
        applyStimulus(1, 4'd4, 0, 16'h0000, 0, 0, 0, 16'h0);
        checkOutput("youngest_wins", 16'h0002, 16'h2222, 2'b01, 0);
        tick();
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        checkOutput("young_load_hides_old", 16'h1111, 16'h2222, 2'b00, 1);
        tick();
        checkOutput("young_load_slot1", 16'h1111, 16'h2222, 2'b00, 1);
        tick();
        checkOutput("young_load_slot2", 16'h1111, 16'h2222, 2'b00, 1);
        tick();
        checkOutput("young_load_retired", 16'h1111, 16'h2222, 2'b00, 0);

        // Writes to r0 are never recorded.
        setSources(4'd0, 4'd5, 16'h1111, 16'h2222);
        applyStimulus(1, 4'd0, 1, 16'hFFFF, 0, 0, 0, 16'h0);
        tick();
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        checkOutput("r0_never_fwd", 16'h1111, 16'h2222, 2'b00, 0);

        // Flush squashes both the entry in slot 0 and the incoming write.
        setSources(4'd6, 4'd5, 16'h1111, 16'h2222);
        applyStimulus(1, 4'd6, 1, 16'h0606, 0, 0, 0, 16'h0);
        tick();
        applyStimulus(1, 4'd6, 1, 16'h0666, 1, 0, 0, 16'h0);
        checkOutput("pre_flush_fwd", 16'h0606, 16'h2222, 2'b01, 0);
        tick();
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        checkOutput("flushed_slot0", 16'h1111, 16'h2222, 2'b00, 0);
        tick();
        checkOutput("flushed_slot1", 16'h1111, 16'h2222, 2'b00, 0);

        // Hold freezes r7 in slot 0; write and flush during hold are ignored.
        setSources(4'd7, 4'd5, 16'h1111, 16'h2222);
        applyStimulus(1, 4'd7, 1, 16'h0077, 0, 0, 0, 16'h0);
        tick();
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        checkOutput("hold_start", 16'h0077, 16'h2222, 2'b01, 0);
        applyStimulus(1, 4'd7, 1, 16'h1234, 1, 1, 0, 16'h0);
        tick();
        checkOutput("hold_1", 16'h0077, 16'h2222, 2'b01, 0);
        tick();
        checkOutput("hold_2", 16'h0077, 16'h2222, 2'b01, 0);
        tick();
        checkOutput("hold_3", 16'h0077, 16'h2222, 2'b01, 0);
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        tick();
        checkOutput("after_hold_slot1", 16'h0077, 16'h2222, 2'b01, 0);
        tick();
        checkOutput("after_hold_slot2", 16'h0077, 16'h2222, 2'b01, 0);
        tick();
        checkOutput("after_hold_retired", 16'h1111, 16'h2222, 2'b00, 0);

        // Load completion on an already-ready entry leaves its data intact.
        setSources(4'd3, 4'd5, 16'h1111, 16'h2222);
        applyStimulus(1, 4'd3, 1, 16'hABCD, 0, 0, 0, 16'h0);
        tick();
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        tick();
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 1, 16'h5555);
        tick();
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        checkOutput("ld_on_ready_ignored", 16'hABCD, 16'h2222, 2'b01, 0);
        tick();

        // Reset in the middle of a load discards it; late load data is ignored.
        setSources(4'd5, 4'd3, 16'h1111, 16'h2222);
        applyStimulus(1, 4'd5, 0, 16'h0, 0, 0, 0, 16'h0);
        tick();
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        checkOutput("mid_load_stall", 16'h1111, 16'h2222, 2'b00, 1);
        tick();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 16'h0, 0, 1, 1, 16'h0BEE);
        checkOutput("reset_masks_outputs", 16'h1111, 16'h2222, 2'b00, 0);
        tick();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 1, 16'h0BEE);
        checkOutput("after_reset_clean", 16'h1111, 16'h2222, 2'b00, 0);
        tick();
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        checkOutput("late_ld_ignored", 16'h1111, 16'h2222, 2'b00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
